// File: rtl/crc16_pkg.sv
// Shared types and constants for the serial CRC-16 frame front end.
package crc16_pkg;

  typedef logic [15:0] crc16_t;

  localparam crc16_t CRC16_POLY = 16'h8005;
  localparam crc16_t CRC16_INIT = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } fsm_e;

endpackage

// File: rtl/crc16_ser_core.sv
// Serial CRC-16 LFSR, MSB-first, one bit absorbed per enabled clock.
module crc16_ser_core
  import crc16_pkg::*;
#(
  parameter crc16_t POLY = CRC16_POLY,
  parameter crc16_t INIT = CRC16_INIT
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   en_i,
  input  logic   clr_i,
  input  logic   data_i,
  output crc16_t crc_o
);

  crc16_t crc_q;
  logic   fb;

  assign fb    = crc_q[15] ^ data_i;
  assign crc_o = crc_q;

  // LFSR register: clear wins over enable so an abort never absorbs a stray bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      crc_q <= INIT;
    end else if (clr_i) begin
      crc_q <= INIT;
    end else if (en_i) begin
      crc_q <= {crc_q[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/crc16_frame_ctrl.sv
// Byte-stream sequencer: serialises framed beats MSB-first into the CRC core
// and presents the frame CRC until the consumer takes it.
module crc16_frame_ctrl
  import crc16_pkg::*;
#(
  parameter int     DATA_W = 8,
  parameter crc16_t POLY   = CRC16_POLY,
  parameter crc16_t INIT   = CRC16_INIT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_last_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic              abort_i,
  output crc16_t            crc_o,
  output logic              crc_valid_o,
  input  logic              crc_ready_i,
  output logic              busy_o
);

  localparam int                CNT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DATA_W - 1);

  fsm_e              state_q, state_d;
  logic [DATA_W-1:0] sh_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              last_q;
  logic              in_frame_q;

  logic   at_last_bit;
  logic   accept;
  logic   crc_take;
  logic   lfsr_en;
  logic   lfsr_clr;
  crc16_t lfsr;

  // The final bit of a beat is the only point where a new beat can join the
  // running frame without a bubble; abort blocks every acceptance.
  assign at_last_bit = (state_q == SHIFT) && (cnt_q == CNT_MAX);
  assign s_ready_o   = !abort_i && ((state_q == IDLE) || (at_last_bit && !last_q));
  assign accept      = s_valid_i && s_ready_o;
  assign crc_take    = (state_q == DONE) && crc_ready_i && !abort_i;
  assign lfsr_en     = (state_q == SHIFT);
  assign lfsr_clr    = abort_i || crc_take;

  assign crc_valid_o = (state_q == DONE);
  assign crc_o       = (state_q == DONE) ? lfsr : INIT;
  assign busy_o      = in_frame_q;

  crc16_ser_core #(
    .POLY (POLY),
    .INIT (INIT)
  ) u_core (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (lfsr_en),
    .clr_i  (lfsr_clr),
    .data_i (sh_q[DATA_W-1]),
    .crc_o  (lfsr)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; abort returns to IDLE from anywhere.
  always_comb begin
    // NOTE: default assigned first so no path through the block leaves state_d unassigned (no latch).
    state_d = state_q;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = SHIFT;
        SHIFT: begin
          if (at_last_bit) begin
            if (accept)      state_d = SHIFT;
            else if (last_q) state_d = DONE;
            else             state_d = IDLE;
          end
        end
        DONE:    if (crc_ready_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Beat shift register, bit counter and frame-tracking flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: the shift register is a plain register, not a memory, so it is reset with the rest of the state.
    if (rst_i) begin
      sh_q       <= '0;
      cnt_q      <= '0;
      last_q     <= 1'b0;
      in_frame_q <= 1'b0;
    end else if (abort_i) begin
      cnt_q      <= '0;
      last_q     <= 1'b0;
      in_frame_q <= 1'b0;
    end else begin
      if (accept) begin
        sh_q       <= s_data_i;
        last_q     <= s_last_i;
        cnt_q      <= '0;
        in_frame_q <= 1'b1;
      end else if (state_q == SHIFT) begin
        sh_q  <= {sh_q[DATA_W-2:0], 1'b0};
        cnt_q <= at_last_bit ? '0 : cnt_q + 1'b1;
      end
      if (crc_take) begin
        in_frame_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_crc16_frame_ctrl.sv
// Directed self-checking bench for crc16_frame_ctrl.
module tb_crc16_frame_ctrl;
  import crc16_pkg::*;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_last = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic              abort = 1'b0;
  crc16_t            crc;
  logic              crc_valid;
  logic              crc_ready = 1'b0;
  logic              busy;

  int     n_tests = 0;
  int     n_fail  = 0;
  int     cyc_cnt = 0;
  crc16_t model_crc;

  logic [7:0] frame_b [0:8];
  int         gap_tab [0:8] = '{3, 0, 5, 1, 2, 4, 0, 5, 1};

  crc16_frame_ctrl #(.DATA_W(DATA_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .s_data_i    (s_data),
    .s_last_i    (s_last),
    .s_valid_i   (s_valid),
    .s_ready_o   (s_ready),
    .abort_i     (abort),
    .crc_o       (crc),
    .crc_valid_o (crc_valid),
    .crc_ready_i (crc_ready),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  function automatic crc16_t model_byte(input crc16_t c, input logic [7:0] b);
    crc16_t r = c;
    for (int i = 7; i >= 0; i--) begin
      logic fb = r[15] ^ b[i];
      r = {r[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat and waits (bounded) for the handshake edge.
  task automatic send_beat(input logic [7:0] d, input logic last, output int waits, output int acc_cyc);
    bit done = 0;
    s_data  = d;
    s_last  = last;
    s_valid = 1'b1;
    waits   = 0;
    acc_cyc = -1;
    while (!done && waits < 50) begin
      @(negedge clk);
      if (s_ready) begin
        @(posedge clk);
        #1;
        acc_cyc = cyc_cnt;
        done    = 1;
      end else begin
        @(posedge clk);
        #1;
        waits++;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (!done) check("beat_accept_timeout", 16'd0, 16'd1);
    model_crc = model_byte(model_crc, d);
  endtask

  // Sends frame_b[0..n-1]; optional idle gaps before each beat.
  task automatic send_frame(input int n, input bit gaps, output int first_cyc, output int wait_sum,
                            output int busy_low);
    int w, a;
    model_crc = CRC16_INIT;
    wait_sum  = 0;
    busy_low  = 0;
    first_cyc = -1;
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) begin
        for (int g = 0; g < gap_tab[i]; g++) begin
          tick();
          if (!busy) busy_low++;
        end
      end
      send_beat(frame_b[i], (i == n - 1), w, a);
      if (i == 0) first_cyc = a;
      else        wait_sum += w;
    end
  endtask

  // Bounded wait for the CRC, compare against model (and constant), then take it.
  task automatic wait_crc(input string tag, input bit use_const, input crc16_t exp_const,
                          input int start_cyc, input int exp_lat);
    int n = 0;
    while (!crc_valid && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 16'(crc_valid), 16'd1);
    if (exp_lat > 0) check({tag, "_latency"}, 16'(cyc_cnt - start_cyc), 16'(exp_lat));
    check({tag, "_crc_model"}, crc, model_crc);
    if (use_const) check({tag, "_crc_const"}, crc, exp_const);
    crc_ready = 1'b1;
    tick();
    crc_ready = 1'b0;
    check({tag, "_busy_after_take"}, 16'(busy), 16'd0);
    check({tag, "_valid_after_take"}, 16'(crc_valid), 16'd0);
  endtask

  task automatic load_123456789();
    for (int i = 0; i < 9; i++) frame_b[i] = 8'h31 + 8'(i);
  endtask

  initial begin
    int fc, ws, bl, w, a, bad;
    crc16_t held;

    // Reset state
    #2;
    check("rst_s_ready", 16'(s_ready), 16'd1);
    check("rst_crc_valid", 16'(crc_valid), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_crc", crc, 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // 1) single-beat frames
    frame_b[0] = 8'h01;
    send_frame(1, 0, fc, ws, bl);
    wait_crc("t1_0x01", 1, 16'h8005, fc, DATA_W);
    frame_b[0] = 8'h00;
    send_frame(1, 0, fc, ws, bl);
    wait_crc("t1_0x00", 1, 16'h0000, fc, DATA_W);

    // 2) back-to-back "123456789"
    load_123456789();
    send_frame(9, 0, fc, ws, bl);
    check("t2_ready_wait_sum", 16'(ws), 16'(8 * (DATA_W - 1)));
    wait_crc("t2_b2b", 1, 16'hFEE8, fc, 9 * DATA_W);

    // 3) same frame with idle gaps
    send_frame(9, 1, fc, ws, bl);
    check("t3_busy_in_gaps", 16'(bl), 16'd0);
    wait_crc("t3_gaps", 1, 16'hFEE8, fc, 0);

    // 4) consumer stalls 10 clks in DONE, then fresh frame "1"
    frame_b[0] = 8'hA5;
    send_frame(1, 0, fc, ws, bl);
    w = 0;
    while (!crc_valid && w < 50) begin
      tick();
      w++;
    end
    held = crc;
    bad  = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (crc !== held || !crc_valid || s_ready) bad++;
    end
    check("t4_hold_stable", 16'(bad), 16'd0);
    wait_crc("t4_stalled", 0, 16'h0000, fc, 0);
    frame_b[0] = 8'h31;
    send_frame(1, 0, fc, ws, bl);
    wait_crc("t4_fresh", 0, 16'h0000, fc, DATA_W);

    // 5) abort mid-byte, abort alongside valid, then clean frame
    model_crc = CRC16_INIT;
    send_beat(8'h41, 1'b0, w, a);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_abort_busy", 16'(busy), 16'd0);
    check("t5_abort_crc", crc, 16'h0000);
    s_data  = 8'hFF;
    s_last  = 1'b1;
    s_valid = 1'b1;
    abort   = 1'b1;
    @(negedge clk);
    check("t5_abort_blocks_ready", 16'(s_ready), 16'd0);
    tick();
    abort   = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("t5_beat_not_taken", 16'(busy), 16'd0);
    load_123456789();
    send_frame(9, 0, fc, ws, bl);
    wait_crc("t5_after_abort", 1, 16'hFEE8, fc, 9 * DATA_W);

    // 6) asynchronous reset mid-SHIFT
    model_crc = CRC16_INIT;
    send_beat(8'h55, 1'b0, w, a);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_s_ready", 16'(s_ready), 16'd1);
    check("t6_rst_busy", 16'(busy), 16'd0);
    check("t6_rst_valid", 16'(crc_valid), 16'd0);
    check("t6_rst_crc", crc, 16'h0000);
    #2;
    rst = 1'b0;
    tick();
    frame_b[0] = 8'h01;
    send_frame(1, 0, fc, ws, bl);
    wait_crc("t6_after_rst", 1, 16'h8005, fc, DATA_W);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
